// File: rtl/jt12_sh_wr_ctl_if.sv
// jt12_sh_wr_ctl_if: single-slot write request/busy handshake between register interface and ring controller
interface jt12_sh_wr_ctl_if #(
    parameter int SLOTW = 5,
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic [SLOTW-1:0] wr_slot;
    logic [WIDTH-1:0] wr_data;
    logic             wr_busy;
    logic             wr_err;
    modport master(output wr_req, wr_slot, wr_data, input wr_busy, wr_err);
    modport slave(input wr_req, wr_slot, wr_data, output wr_busy, wr_err);
endinterface

// File: rtl/jt12_sh_wr_ctl.sv
// jt12_sh_wr_ctl: slot counter, clear sweep and single-slot write injection for a recirculating ring
module jt12_sh_wr_ctl #(
    parameter int              WIDTH  = 8,
    parameter int              STAGES = 24,
    parameter int              SLOTW  = 5,
    parameter logic [WIDTH-1:0] RSTVAL = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    jt12_sh_wr_ctl_if.slave   wr,
    input  logic [WIDTH-1:0]  ring_drop,
    output logic [WIDTH-1:0]  ring_din,
    output logic [SLOTW-1:0]  slot,
    output logic              slot_zero,
    output logic              ready
);
    localparam logic [SLOTW-1:0] LAST = SLOTW'(STAGES - 1);
    typedef enum logic [1:0] {CLEAR, IDLE, PEND} state_t;
    state_t           state, state_nx;
    logic [SLOTW-1:0] cnt, pend_slot;
    logic [WIDTH-1:0] pend_data;
    logic             sweep_done, accept, land, hit;

    assign hit        = slot == pend_slot;
    assign sweep_done = state == CLEAR && clk_en && cnt == LAST;
    assign accept     = state == IDLE && wr.wr_req && wr.wr_slot <= LAST;
    assign land       = state == PEND && clk_en && hit;
    assign slot_zero  = slot == '0;

    // state register; reset restarts the clear sweep and drops any pending write
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= CLEAR;
        else     state <= state_nx;

    // next state, busy flag and ring input selection
    always_comb begin
        state_nx   = sweep_done ? IDLE : accept ? PEND : land ? IDLE : state;
        wr.wr_busy = state != IDLE;
        ring_din   = state == CLEAR ? RSTVAL : (state == PEND && hit) ? pend_data : ring_drop;
    end

    // slot counter and sweep counter advance with the pipeline step only
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            slot <= '0;
            cnt  <= '0;
        end else if (clk_en) begin
            slot <= slot == LAST ? '0 : slot + SLOTW'(1);
            cnt  <= state == CLEAR ? cnt + SLOTW'(1) : cnt;
        end

    // request capture, out-of-range rejection pulse and sticky ready
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend_slot <= '0;
            pend_data <= '0;
            wr.wr_err <= 1'b0;
            ready     <= 1'b0;
        end else begin
            pend_slot <= accept ? wr.wr_slot : pend_slot;
            pend_data <= accept ? wr.wr_data : pend_data;
            wr.wr_err <= state == IDLE && wr.wr_req && wr.wr_slot > LAST;
            ready     <= ready | sweep_done;
        end
endmodule

// File: tb/tb_jt12_sh_wr_ctl.sv
// tb_jt12_sh_wr_ctl: directed scoreboard bench for the ring write controller with a behavioural ring
module tb_jt12_sh_wr_ctl;
    logic       clk = 0, rst = 1, clk_en = 0, en_run = 0, fill = 1;
    logic [7:0] ring_drop, ring_din;
    logic [4:0] slot;
    logic       slot_zero, ready;
    logic [7:0] ring [24];
    logic [7:0] exp_mem [24];
    typedef struct packed {logic [4:0] s; logic [7:0] v;} exp_t;
    exp_t       q[$];
    exp_t       e;
    int         checks = 0, failures = 0;
    int         n, errs, busy_bad;
    logic [4:0] s_frz;
    logic [7:0] din_frz, drop_frz;
    logic       busy_frz;

    jt12_sh_wr_ctl_if #(.SLOTW(5), .WIDTH(8)) wif();

    jt12_sh_wr_ctl #(.WIDTH(8), .STAGES(24), .SLOTW(5), .RSTVAL(8'h00)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wif.slave),
        .ring_drop(ring_drop), .ring_din(ring_din), .slot(slot),
        .slot_zero(slot_zero), .ready(ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        clk_en = en_run ? ~clk_en : 1'b0;
    end

    // behavioural 24-deep shift ring, preloadable with 0xFF
    always @(posedge clk)
        if (fill) for (int i = 0; i < 24; i++) ring[i] <= 8'hFF;
        else if (clk_en) begin
            ring[0] <= ring_din;
            for (int i = 1; i < 24; i++) ring[i] <= ring[i-1];
        end
    assign ring_drop = ring[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: pop the expected slot value when that slot sits at ring_drop
    initial forever begin
        @(negedge clk);
        if (q.size() != 0 && clk_en && slot == q[0].s) begin
            e = q.pop_front();
            chk($sformatf("ring_slot%0d", e.s), {24'd0, ring_drop}, {24'd0, e.v});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot_en(input logic [4:0] s);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #3;
            if (slot == s && clk_en) return;
        end
        chk("wait_slot_timeout", 0, 1);
    endtask

    task automatic issue(input logic [4:0] s, input logic [7:0] d);
        wif.wr_req  = 1'b1;
        wif.wr_slot = s;
        wif.wr_data = d;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (clk_en) cnt++;
            if (!wif.wr_busy) return;
        end
        chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            step();
            if (ready) return;
        end
        chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic sweep_check();
        int s0;
        s0 = int'(slot);
        for (int i = 0; i < 24; i++) q.push_back('{s: 5'((s0 + i) % 24), v: exp_mem[(s0 + i) % 24]});
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            chk("sweep_drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        wif.wr_req = 0; wif.wr_slot = 0; wif.wr_data = 0;
        for (int i = 0; i < 24; i++) exp_mem[i] = 8'h00;
        repeat (3) step();
        chk("rst_busy", wif.wr_busy, 1);
        chk("rst_ready", ready, 0);
        chk("rst_slot", slot, 0);
        chk("rst_slot_zero", slot_zero, 1);
        chk("rst_err", wif.wr_err, 0);
        chk("rst_din", ring_din, 8'h00);
        fill = 0; rst = 0; en_run = 1;
        issue(5'd30, 8'h77);
        n = 0; errs = 0; busy_bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (clk_en) n++;
            if (wif.wr_err) errs++;
            if (ready) break;
            if (!wif.wr_busy) busy_bad++;
        end
        wif.wr_req = 0;
        chk("sweep_edges", n, 24);
        chk("clear_no_err", errs, 0);
        chk("clear_busy", busy_bad, 0);
        chk("ready_idle_busy", wif.wr_busy, 0);
        sweep_check();

        wait_slot_en(5'd2);
        issue(5'd5, 8'hA5);
        step();
        wif.wr_req = 0;
        chk("t2_busy", wif.wr_busy, 1);
        wait_idle(n);
        chk("t2_edges", n, 3);
        chk("t2_land_slot", slot, 6);
        exp_mem[5] = 8'hA5;
        sweep_check();
        sweep_check();

        wait_slot_en(5'd8);
        issue(5'd7, 8'h5A);
        step();
        wif.wr_req = 0;
        wait_idle(n);
        chk("t3_edges", n, 23);
        exp_mem[7] = 8'h5A;
        sweep_check();

        step();
        issue(5'd24, 8'hEE);
        step();
        wif.wr_req = 0;
        chk("t4_err", wif.wr_err, 1);
        chk("t4_busy", wif.wr_busy, 0);
        step();
        chk("t4_err_pulse", wif.wr_err, 0);
        sweep_check();

        wait_slot_en(5'd10);
        issue(5'd12, 8'h12);
        step();
        wif.wr_slot = 5'd15;
        wif.wr_data = 8'hF0;
        wait_idle(n);
        chk("t5_first_edges", n, 2);
        step();
        chk("t5_accept_after_land", wif.wr_busy, 1);
        wif.wr_req = 0;
        wait_idle(n);
        chk("t5_second_edges", n, 3);
        exp_mem[12] = 8'h12;
        exp_mem[15] = 8'hF0;
        sweep_check();

        wait_slot_en(5'd11);
        issue(5'd10, 8'h3C);
        step();
        wif.wr_req = 0;
        repeat (3) step();
        rst = 1;
        #1;
        chk("t6_rst_busy", wif.wr_busy, 1);
        chk("t6_rst_ready", ready, 0);
        chk("t6_rst_slot", slot, 0);
        step();
        rst = 0;
        repeat (4) step();
        en_run = 0;
        repeat (2) step();
        s_frz = slot; busy_frz = wif.wr_busy; din_frz = ring_din; drop_frz = ring_drop;
        repeat (50) step();
        chk("t6_frz_slot", slot, s_frz);
        chk("t6_frz_busy", wif.wr_busy, busy_frz);
        chk("t6_frz_din", ring_din, din_frz);
        chk("t6_frz_drop", ring_drop, drop_frz);
        chk("t6_frz_ready", ready, 0);
        en_run = 1;
        wait_ready();
        chk("t6_ready", ready, 1);
        for (int i = 0; i < 24; i++) exp_mem[i] = 8'h00;
        sweep_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
